// File: rtl/bin_fc_layer_seq.sv
// Binary-weight fully-connected layer: one signed activation per beat, OUT_DIM parallel +/-x accumulators.
// Latency: result registered on the edge of the last accepted beat, out_valid high the following cycle.
// Backpressure: in_ready low while a result is held; result held stable until out_valid && out_ready.
// Optional: define BIN_FC_RELU_EN to clamp negative saturated results to zero.
module bin_fc_layer_seq #(
   parameter int IN_DIM    = 10,
   parameter int OUT_DIM   = 10,
   parameter int DATA_W    = 8,
   parameter int OUT_SHIFT = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_data,
   input  logic [OUT_DIM-1:0]        in_wcol,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OUT_DIM*DATA_W-1:0] out_data,
   output logic                      err_len
);

   localparam int ACC_W = DATA_W + $clog2(IN_DIM) + 1;
   localparam int CNT_W = $clog2(IN_DIM);

   // Saturation bounds of the DATA_W result, expressed in accumulator width
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0]       OUT_MAX = SAT_MAX[DATA_W-1:0];
   localparam logic [DATA_W-1:0]       OUT_MIN = SAT_MIN[DATA_W-1:0];

   typedef enum logic {
      S_ACCUM = 1'b0,
      S_OUT   = 1'b1
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [CNT_W-1:0]          r_cnt;
   logic signed [ACC_W-1:0]   r_acc [OUT_DIM];
   logic [OUT_DIM*DATA_W-1:0] r_out_data;
   logic                      r_err_len;

   logic                      w_in_fire;
   logic                      w_out_fire;
   logic                      w_last_beat;
   logic signed [ACC_W-1:0]   w_x_ext;
   logic signed [ACC_W-1:0]   w_acc_nxt [OUT_DIM];
   logic signed [ACC_W-1:0]   w_sh      [OUT_DIM];
   logic [DATA_W-1:0]         w_sat     [OUT_DIM];
   logic [OUT_DIM*DATA_W-1:0] w_res;

   // Activation sign-extended once; ACC_W has headroom so negating -2^(DATA_W-1) is exact
   assign w_x_ext     = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
   assign w_last_beat = (r_cnt == CNT_W'(IN_DIM-1));

   // Per-neuron next sum, rescale and saturation
   for (genvar j = 0; j < OUT_DIM; j++) begin : g_neuron
      assign w_acc_nxt[j] = in_wcol[j] ? (r_acc[j] + w_x_ext) : (r_acc[j] - w_x_ext);
      assign w_sh[j]      = w_acc_nxt[j] >>> OUT_SHIFT;
      assign w_sat[j]     = (w_sh[j] > SAT_MAX) ? OUT_MAX :
                            (w_sh[j] < SAT_MIN) ? OUT_MIN : w_sh[j][DATA_W-1:0];
`ifdef BIN_FC_RELU_EN
      assign w_res[j*DATA_W +: DATA_W] = w_sat[j][DATA_W-1] ? '0 : w_sat[j];
`else
      assign w_res[j*DATA_W +: DATA_W] = w_sat[j];
`endif
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_ACCUM;
      else        r_state <= w_state_nxt;
   end

   // Next state, handshake outputs and transfer strobes
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_in_fire   = 1'b0;
      w_out_fire  = 1'b0;
      case (r_state)
         S_ACCUM: begin
            in_ready  = 1'b1;
            w_in_fire = in_valid;
            if (in_valid && w_last_beat) w_state_nxt = S_OUT;
         end
         S_OUT: begin
            out_valid  = 1'b1;
            w_out_fire = out_ready;
            if (out_ready) w_state_nxt = S_ACCUM;
         end
         default: w_state_nxt = S_ACCUM;
      endcase
   end

   // Beat counter: advances per accepted beat, wraps after the last one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             r_cnt <= '0;
      else if (w_out_fire)    r_cnt <= '0;
      else if (w_in_fire)     r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
   end

   // Accumulators: add/subtract on accepted beats, cleared once the result is taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < OUT_DIM; j++) r_acc[j] <= '0;
      end else if (w_out_fire) begin
         for (int j = 0; j < OUT_DIM; j++) r_acc[j] <= '0;
      end else if (w_in_fire) begin
         for (int j = 0; j < OUT_DIM; j++) r_acc[j] <= w_acc_nxt[j];
      end
   end

   // Result register captures the final sums on the last beat and holds them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     r_out_data <= '0;
      else if (w_in_fire && w_last_beat) r_out_data <= w_res;
   end

   // Sticky length error: in_last must mark exactly the final beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  r_err_len <= 1'b0;
      else if (w_in_fire && (in_last != w_last_beat)) r_err_len <= 1'b1;
   end

   assign out_data = r_out_data;
   assign err_len  = r_err_len;

endmodule

// File: tb/tb_bin_fc_layer_seq.sv
// Bench for bin_fc_layer_seq: two instances (OUT_SHIFT 0 and 2) share one input stream and
// are checked every cycle against an integer reference model, plus literal result checks.
module tb_bin_fc_layer_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic [9:0]  in_wcol;
   logic        in_last;
   logic        out_ready;

   logic        in_ready0, in_ready2, out_valid0, out_valid2, err0, err2;
   logic [79:0] o0, o2;

   int n_chk = 0;
   int n_pass = 0;
   int rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random

   logic [7:0] vx[10];
   logic [9:0] vw[10];
   logic       vlast[10];

   // reference model state
   bit m_hold;
   int m_cnt;
   bit m_err;
   int m_sum[10];
   int m_raw[10];

   always #5 clk = ~clk;

   bin_fc_layer_seq #(.IN_DIM(10), .OUT_DIM(10), .DATA_W(8), .OUT_SHIFT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
      .in_wcol(in_wcol), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(o0), .err_len(err0));

   bin_fc_layer_seq #(.IN_DIM(10), .OUT_DIM(10), .DATA_W(8), .OUT_SHIFT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
      .in_wcol(in_wcol), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
      .out_data(o2), .err_len(err2));

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   task automatic fail_now(input string nm);
      n_chk++;
      $display("FAIL %s: wait bound expired at %0t", nm, $time);
   endtask

   // Expected element: floor shift, clamp to int8, optional ReLU
   function automatic logic [7:0] expv(input int raw, input int sh);
      int v;
      v = raw >>> sh;
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
`ifdef BIN_FC_RELU_EN
      if (v < 0) v = 0;
`endif
      return v[7:0];
   endfunction

   function automatic logic [79:0] exp_vec(input int sh);
      logic [79:0] r;
      r = '0;
      for (int j = 0; j < 10; j++) r[j*8 +: 8] = expv(m_raw[j], sh);
      return r;
   endfunction

   function automatic logic [79:0] rep(input int v);
      logic [79:0] r;
      for (int j = 0; j < 10; j++) r[j*8 +: 8] = v[7:0];
      return r;
   endfunction

   // Per-cycle compare against the model, then advance the model by what the next edge accepts
   always @(negedge clk) begin
      if (!rst_n) begin
         m_hold = 0; m_cnt = 0; m_err = 0;
         for (int j = 0; j < 10; j++) begin m_sum[j] = 0; m_raw[j] = 0; end
      end
      chk("in_ready",  {78'd0, in_ready0, in_ready2},   {78'd0, !m_hold, !m_hold});
      chk("out_valid", {78'd0, out_valid0, out_valid2}, {78'd0, m_hold, m_hold});
      chk("err_len",   {78'd0, err0, err2},             {78'd0, m_err, m_err});
      chk("out_data_sh0", o0, exp_vec(0));
      chk("out_data_sh2", o2, exp_vec(2));
      if (rst_n) begin
         if (!m_hold && in_valid) begin
            for (int j = 0; j < 10; j++)
               m_sum[j] += in_wcol[j] ? int'($signed(in_data)) : -int'($signed(in_data));
            if (in_last != (m_cnt == 9)) m_err = 1;
            if (m_cnt == 9) begin
               for (int j = 0; j < 10; j++) m_raw[j] = m_sum[j];
               m_hold = 1;
               m_cnt = 0;
            end else begin
               m_cnt++;
            end
         end else if (m_hold && out_ready) begin
            m_hold = 0;
            for (int j = 0; j < 10; j++) m_sum[j] = 0;
         end
      end
   end

   // Consumer ready driver
   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [7:0] x, input logic [9:0] w, input logic l);
      bit got;
      got = 0;
      in_valid = 1'b1; in_data = x; in_wcol = w; in_last = l;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clk);
         got = in_ready0;
         cyc();
      end
      in_valid = 1'b0;
      if (!got) fail_now("beat_accept");
   endtask

   task automatic set_uniform(input logic [7:0] x, input logic [9:0] w);
      for (int k = 0; k < 10; k++) begin vx[k] = x; vw[k] = w; vlast[k] = (k == 9); end
   endtask

   task automatic run_vec(input bit stall);
      for (int k = 0; k < 10; k++) begin
         if (stall && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) cyc();
         send_beat(vx[k], vw[k], vlast[k]);
      end
   endtask

   task automatic wait_out();
      bit seen;
      seen = 0;
      for (int t = 0; t < 40 && !seen; t++) begin
         if (out_valid0) seen = 1;
         else cyc();
      end
      if (!seen) fail_now("out_valid_wait");
   endtask

   task automatic chk_lit(input string nm, input int v0, input int v2);
      chk({nm, "_sh0"}, o0, rep(v0));
      chk({nm, "_sh2"}, o2, rep(v2));
   endtask

   initial begin
      int neg;
      logic [7:0] neg_b;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_wcol = '0; in_last = 1'b0; out_ready = 1'b1;
      repeat (3) cyc();
      chk("reset_in_ready", {79'd0, in_ready0}, 80'd1);
      chk("reset_out_data", o0, 80'd0);
      rst_n = 1'b1;
      cyc();

      // x=10, all +1: 100 (shift 2: 25), valid right after last beat
      set_uniform(8'd10, 10'h3FF);
      run_vec(0);
      chk("latency_valid", {79'd0, out_valid0}, 80'd1);
      chk_lit("sum100", 100, 25);
      cyc();

      // saturation: neuron0 +1, neuron1 -1
      set_uniform(8'd100, 10'h3FD);
      run_vec(0);
      neg = -128;
`ifdef BIN_FC_RELU_EN
      neg = 0;
`endif
      neg_b = neg[7:0];
      chk("sat_pos_sh0", {72'd0, o0[7:0]},  {72'd0, 8'd127});
      chk("sat_neg_sh0", {72'd0, o0[15:8]}, {72'd0, neg_b});
      chk("sat_pos_sh2", {72'd0, o2[7:0]},  {72'd0, 8'd127});
      chk("sat_neg_sh2", {72'd0, o2[15:8]}, {72'd0, neg_b});
      cyc();

      // alternating +5/-5 cancels
      set_uniform(8'd5, 10'h3FF);
      for (int k = 1; k < 10; k += 2) vx[k] = 8'hFB;
      run_vec(1);
      chk_lit("alt_zero", 0, 0);
      cyc();

      // x=7: 70, shifted 17
      set_uniform(8'd7, 10'h3FF);
      run_vec(0);
      chk_lit("seven", 70, 17);
      cyc();

      // held result under backpressure
      rdy_mode = 0;
      set_uniform(8'd2, 10'h3FF);
      run_vec(0);
      wait_out();
      for (int c = 0; c < 5; c++) begin
         chk("hold_in_ready", {79'd0, in_ready0}, 80'd0);
         chk_lit("hold_data", 20, 5);
         cyc();
      end
      rdy_mode = 1;

      // in_last on beat 3: sticky error, vector still completes after 10 beats
      set_uniform(8'd1, 10'h3FF);
      for (int k = 0; k < 10; k++) vlast[k] = (k == 3);
      run_vec(0);
      chk("err_sticky", {78'd0, err0, err2}, {78'd0, 2'b11});
      chk_lit("err_vec", 10, 2);
      cyc();

      // reset after 4 beats discards partial sums and held state
      set_uniform(8'd50, 10'h3FF);
      for (int k = 0; k < 4; k++) send_beat(vx[k], vw[k], vlast[k]);
      rst_n = 1'b0;
      #1;
      chk("rst_async_data", o0, 80'd0);
      chk("rst_async_err", {79'd0, err0}, 80'd0);
      cyc();
      rst_n = 1'b1;
      cyc();
      set_uniform(8'd3, 10'h3FF);
      run_vec(0);
      chk_lit("no_residue", 30, 7);
      cyc();

      // all -1 weights
      set_uniform(8'd5, 10'h000);
`ifdef BIN_FC_RELU_EN
      run_vec(0);
      chk_lit("all_neg", 0, 0);
`else
      run_vec(0);
      chk_lit("all_neg", -50, -13);
`endif
      cyc();

      // randomized vectors with stalls and random consumer ready
      rdy_mode = 2;
      for (int v = 0; v < 30; v++) begin
         for (int k = 0; k < 10; k++) begin
            vx[k] = 8'($urandom);
            if ($urandom_range(0, 4) == 0) vx[k] = 8'h80;
            vw[k] = 10'($urandom);
            vlast[k] = (k == 9);
         end
         if ($urandom_range(0, 9) == 0) vlast[$urandom_range(0, 8)] = 1'b1;
         run_vec(1);
      end
      rdy_mode = 1;
      repeat (4) cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
